// File: rtl/mem_pkg.sv
// Shared widths, RV32I load/store size encodings and FSM state type for the data memory responder.
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = WORD_W / BYTE_W;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Rejects a request: bad direction, misalignment, out of range, reserved or unsigned-store size.
  function automatic logic access_error(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo,
                                        input logic       out_of_range);
    logic err;
    err = (rd == wr) || out_of_range;
    case (f3)
      F3_B:    err = err;
      F3_H:    err = err | addr_lo[0];
      F3_W:    err = err | (addr_lo != 2'b00);
      F3_BU:   err = err | wr;
      F3_HU:   err = err | wr | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/Load_Data_Aligner.sv
// Selects the addressed byte/half/word lane of a memory word and sign- or zero-extends it.
module Load_Data_Aligner
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] mem_word,
  input  logic [1:0]        byte_offset,
  input  logic [2:0]        funct3,
  output logic [WORD_W-1:0] load_data_c
);

  logic [BYTE_W-1:0] byte_c;
  logic [HALF_W-1:0] half_c;

  always_comb begin
    byte_c      = BYTE_W'(mem_word >> {byte_offset, 3'b000});
    half_c      = HALF_W'(mem_word >> {byte_offset[1], 4'b0000});
    load_data_c = '0;
    case (funct3)
      F3_B:    load_data_c = {{(WORD_W-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
      F3_BU:   load_data_c = {{(WORD_W-BYTE_W){1'b0}}, byte_c};
      F3_H:    load_data_c = {{(WORD_W-HALF_W){half_c[HALF_W-1]}}, half_c};
      F3_HU:   load_data_c = {{(WORD_W-HALF_W){1'b0}}, half_c};
      F3_W:    load_data_c = mem_word;
      default: load_data_c = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding load/store responder: accept, wait WAIT_STATES cycles, access memory, hold response.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        pll_1_200MHz,
  input  logic        system_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] read_data,
  output logic        resp_error
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAST_WAIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t state_q, next_state;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  logic              cap_read, cap_write;
  logic [2:0]        cap_f3;
  logic [31:0]       cap_addr, cap_wdata;

  logic              acc_read, acc_write;
  logic [2:0]        acc_f3;
  logic [31:0]       acc_addr, acc_wdata;

  logic              err_c, enter_resp_c, commit_c, accept_c;
  logic [IDX_W-1:0]  word_idx_c;
  logic [WORD_W-1:0] mem_word_c, load_data_c, wlane_c;
  logic [LANES-1:0]  be_c;
  logic              req_ready_d, resp_valid_d, resp_error_d;
  logic [31:0]       read_data_d;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  assign accept_c = (state_q == ST_IDLE) && req_valid && req_ready;

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    acc_read  = cap_read;
    acc_write = cap_write;
    acc_f3    = cap_f3;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    if (state_q == ST_IDLE) begin
      acc_read  = mem_read;
      acc_write = mem_write;
      acc_f3    = funct3;
      acc_addr  = address;
      acc_wdata = write_data;
    end
  end

  assign err_c      = access_error(acc_read, acc_write, acc_f3, acc_addr[1:0],
                                   ({2'b00, acc_addr[31:2]} >= DEPTH_WORDS));
  assign word_idx_c = acc_addr[IDX_W+1:2];
  assign mem_word_c = mem[word_idx_c];

  Load_Data_Aligner u_aligner (
    .mem_word    (mem_word_c),
    .byte_offset (acc_addr[1:0]),
    .funct3      (acc_f3),
    .load_data_c (load_data_c)
  );

  // Store lane enables and lane-replicated store data.
  always_comb begin
    be_c    = '0;
    wlane_c = acc_wdata;
    case (acc_f3)
      F3_B: begin
        be_c    = 4'b0001 << acc_addr[1:0];
        wlane_c = {4{acc_wdata[7:0]}};
      end
      F3_H: begin
        be_c    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{acc_wdata[15:0]}};
      end
      F3_W:    be_c = '1;
      default: be_c = '0;
    endcase
  end

  always_comb begin
    next_state   = state_q;
    wait_cnt_d   = wait_cnt_q;
    enter_resp_c = 1'b0;
    read_data_d  = read_data;
    resp_error_d = resp_error;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          wait_cnt_d = '0;
          if (WAIT_STATES == 0) begin
            next_state   = ST_RESP;
            enter_resp_c = 1'b1;
          end else begin
            next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          next_state   = ST_RESP;
          enter_resp_c = 1'b1;
          wait_cnt_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (enter_resp_c) begin
      resp_error_d = err_c;
      read_data_d  = (err_c || acc_write) ? 32'd0 : load_data_c;
    end
    commit_c     = enter_resp_c && !err_c && acc_write;
    req_ready_d  = (next_state == ST_IDLE);
    resp_valid_d = (next_state == ST_RESP);
  end

  always_ff @(posedge pll_1_200MHz or posedge system_reset) begin
    if (system_reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      read_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      state_q    <= next_state;
      wait_cnt_q <= wait_cnt_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      read_data  <= read_data_d;
      resp_error <= resp_error_d;
    end
  end

  // Request capture on accept.
  always_ff @(posedge pll_1_200MHz or posedge system_reset) begin
    if (system_reset) begin
      cap_read  <= 1'b0;
      cap_write <= 1'b0;
      cap_f3    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept_c) begin
      cap_read  <= mem_read;
      cap_write <= mem_write;
      cap_f3    <= funct3;
      cap_addr  <= address;
      cap_wdata <= write_data;
    end
  end

  // Array is not reset; stores commit only on the edge entering RESP.
  always_ff @(posedge pll_1_200MHz) begin
    if (commit_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (be_c[i]) mem[word_idx_c][i*BYTE_W +: BYTE_W] <= wlane_c[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: directed RV32I load/store cases, errors, stall, reset abort, random mix.
module tb_data_memory_responder;

  localparam int unsigned WS = 1;

  logic        clk = 1'b0;
  logic        system_reset;
  logic        req_valid, req_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, write_data;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] read_data;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mm [0:7];

  data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
    .pll_1_200MHz (clk),
    .system_reset (system_reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .address      (address),
    .write_data   (write_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .read_data    (read_data),
    .resp_error   (resp_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, push its expectation, then wait for and score the response.
  task automatic do_req(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input int hold);
    exp_t e;
    int   lat;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 32) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; write_data = wd;
    req_valid = 1'b1;
    @(posedge clk);
    e.data = exp_d;
    e.err  = exp_e;
    sb.push_back(e);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && lat < 32) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(WS + 1));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, read_data, e.data);
      check({tag, "_err"}, 32'(resp_error), 32'(e.err));
      check({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
      // Stall: a competing store is presented and must be ignored.
      for (int i = 0; i < hold; i++) begin
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
        address = 32'h10; write_data = 32'h0; req_valid = 1'b1;
        @(negedge clk);
        check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_hold_data"}, read_data, e.data);
        check({tag, "_hold_err"}, 32'(resp_error), 32'(e.err));
        check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Reference behaviour for the random window 0x40..0x5F.
  function automatic void model_op(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   output logic [31:0] ed, output logic ee);
    int          w;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    w    = int'((a - 32'h40) >> 2);
    word = mm[w];
    b    = word[8*a[1:0] +: 8];
    h    = word[16*a[1] +: 16];
    ee   = (rd == wr) || (f3 == 3'd3) || (f3 >= 3'd6) || (wr && (f3 == 3'd4 || f3 == 3'd5))
           || ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'b00));
    ed   = 32'd0;
    if (!ee && rd) begin
      case (f3)
        3'd0:    ed = {{24{b[7]}}, b};
        3'd4:    ed = {24'd0, b};
        3'd1:    ed = {{16{h[15]}}, h};
        3'd5:    ed = {16'd0, h};
        default: ed = word;
      endcase
    end
    if (!ee && wr) begin
      case (f3)
        3'd0:    mm[w][8*a[1:0] +: 8] = wd[7:0];
        3'd1:    mm[w][16*a[1] +: 16] = wd[15:0];
        default: mm[w] = wd;
      endcase
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ed;
    logic        ee;
    system_reset = 1'b1;
    req_valid = 1'b0; resp_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; address = 32'h0; write_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    system_reset = 1'b0;

    do_req("sw10", 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    do_req("lw10", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    do_req("lb13", 1, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 0);
    do_req("lbu13", 1, 0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0, 0);
    do_req("lh12", 1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 0);
    do_req("lhu10", 1, 0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0, 0);
    do_req("sb11", 0, 1, 3'b000, 32'h11, 32'h00000055, 32'h0, 0, 0);
    do_req("lw10_sb", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0, 0);
    do_req("sh12", 0, 1, 3'b001, 32'h12, 32'h00001234, 32'h0, 0, 0);
    do_req("lw10_sh", 1, 0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 0, 0);

    do_req("err_lw11", 1, 0, 3'b010, 32'h11, 32'h0, 32'h0, 1, 0);
    do_req("err_sh13", 0, 1, 3'b001, 32'h13, 32'hAAAAAAAA, 32'h0, 1, 0);
    do_req("err_lw1000", 1, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, 0);
    do_req("err_rdwr", 1, 1, 3'b010, 32'h10, 32'h11111111, 32'h0, 1, 0);
    do_req("err_sbu", 0, 1, 3'b100, 32'h10, 32'h22222222, 32'h0, 1, 0);
    do_req("err_f3_011", 1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 0);
    do_req("lw10_after_err", 1, 0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 0, 0);

    do_req("stall_lw10", 1, 0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 0, 5);
    do_req("lw10_after_stall", 1, 0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 0, 0);

    // Reset during WAIT aborts a pending store.
    do_req("sw20", 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
    address = 32'h20; write_data = 32'hFFFFFFFF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    system_reset = 1'b1;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_read_data", read_data, 32'd0);
    check("abort_resp_error", 32'(resp_error), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    system_reset = 1'b0;
    check("abort_idle_valid", 32'(resp_valid), 32'd0);
    do_req("lw20_after_abort", 1, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0);

    // Random mix over a small window tracked by the reference model.
    for (int i = 0; i < 8; i++) begin
      mm[i] = $urandom;
      do_req("rnd_init", 0, 1, 3'b010, 32'h40 + 32'(i * 4), mm[i], 32'h0, 0, 0);
    end
    for (int i = 0; i < 60; i++) begin
      int          sel;
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      sel = int'($urandom_range(0, 9));
      rd  = (sel < 5);
      wr  = (sel >= 4);
      f3  = 3'($urandom_range(0, 7));
      a   = 32'h40 + 32'($urandom_range(0, 31));
      wd  = $urandom;
      model_op(rd, wr, f3, a, wd, ed, ee);
      do_req("rnd", rd, wr, f3, a, wd, ed, ee, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
